// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the default mailbox address / pass value.
package dmem_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_MAILBOX_ADDR = 32'd100;
    localparam logic [31:0] DEFAULT_EXPECT_DATA  = 32'd25;

endpackage

// File: rtl/dmem_ram.sv
// Word-wide RAM for the data-memory responder: synchronous write and
// asynchronous read. Contents are never reset.
module dmem_ram #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory plus pass/fail mailbox for a processor test harness.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fail on misaligned stores.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter logic [31:0] MAILBOX_ADDR = DEFAULT_MAILBOX_ADDR,
    parameter logic [31:0] EXPECT_DATA  = DEFAULT_EXPECT_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    state_t        state_q, state_d;
    logic          done_q, pass_q;
    logic [15:0]   count_q;
    logic          count_inc;
    logic          ram_we;
    logic          is_mbox;
    logic          in_range;
    logic          misaligned;
    logic [AW-1:0] index;
    logic [31:0]   ram_rdata;

    // Byte-offset bits are dropped for decode; accesses are word based.
    assign index    = data_addr[AW+1:2];
    assign in_range = (data_addr < RAM_BYTES);
    assign is_mbox  = ({data_addr[31:2], 2'b00} == MAILBOX_ADDR);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (data_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (index),
        .wdata (write_data),
        .rdata (ram_rdata)
    );

    // Mailbox decode wins over the RAM when the two overlap.
    always_comb begin
        read_data = 32'h0;
        if (is_mbox) begin
            read_data = {30'b0, pass_q, done_q};
        end else if (in_range) begin
            read_data = ram_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        count_inc = 1'b0;
        if (reset && mem_write && (state_q == RUN)) begin
            if (misaligned) begin
                state_d = FAIL;
            end else if (is_mbox) begin
                count_inc = 1'b1;
                state_d   = (write_data == EXPECT_DATA) ? PASS : FAIL;
            end else if (in_range) begin
                ram_we    = 1'b1;
                count_inc = 1'b1;
            end else begin
                state_d = FAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d != RUN);
            pass_q  <= (state_d == PASS);
            if (count_inc && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign store_count = count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (default build, DEPTH=64,
// mailbox at 100, pass value 25).
module tb_data_mem_responder;

    typedef struct {
        logic        rst_n;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_done;
        logic        exp_pass;
        logic        chk_cnt;
        logic [15:0] exp_cnt;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        pass;
    logic [15:0] store_count;

    int   total_checks = 0;
    int   passed_checks = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH        (64),
        .MAILBOX_ADDR (32'd100),
        .EXPECT_DATA  (32'd25)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_write   (mem_write),
        .data_addr   (data_addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .done        (done),
        .pass        (pass),
        .store_count (store_count)
    );

    task automatic addVec(input logic rst_n, input logic mw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk_rd, input logic [31:0] exp_rd,
                          input logic exp_done, input logic exp_pass, input logic chk_cnt,
                          input logic [15:0] exp_cnt, input string name);
        vec_t v;
        v.rst_n = rst_n; v.mw = mw; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_done = exp_done;
        v.exp_pass = exp_pass; v.chk_cnt = chk_cnt; v.exp_cnt = exp_cnt;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show this cycle.
    task automatic applyStimulus(input vec_t v);
        reset      = v.rst_n;
        mem_write  = v.mw;
        data_addr  = v.addr;
        write_data = v.wdata;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            total_checks++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = exp_q.pop_front();
        if (e.chk_rd) compare({e.name, ".read_data"}, read_data, e.exp_rd);
        compare({e.name, ".done"}, {31'b0, done}, {31'b0, e.exp_done});
        compare({e.name, ".pass"}, {31'b0, pass}, {31'b0, e.exp_pass});
        if (e.chk_cnt) compare({e.name, ".store_count"}, {16'b0, store_count}, {16'b0, e.exp_cnt});
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expectations describe outputs seen during a row, i.e. the effect of earlier rows.
        addVec(1, 0, 4096, 0,            1, 0,            0, 0, 1, 0, "reset_state");
        addVec(1, 1, 96,   7,            0, 0,            0, 0, 1, 0, "st7_96");
        addVec(1, 0, 96,   0,            1, 7,            0, 0, 1, 1, "ld96");
        addVec(1, 1, 0,    11,           0, 0,            0, 0, 1, 1, "st11_0");
        addVec(1, 1, 4,    12,           0, 0,            0, 0, 1, 2, "st12_4");
        addVec(1, 1, 8,    32'h22,       0, 0,            0, 0, 1, 3, "st22_8");
        addVec(1, 0, 0,    0,            1, 11,           0, 0, 1, 4, "ld0");
        addVec(1, 0, 4,    0,            1, 12,           0, 0, 1, 4, "ld4");
        addVec(1, 1, 98,   13,           1, 7,            0, 0, 1, 4, "st13_98");
        addVec(1, 0, 96,   0,            1, 13,           0, 0, 1, 5, "ld96_after98");
        addVec(1, 1, 252,  32'hDEADBEEF, 0, 0,            0, 0, 1, 5, "st_252");
        addVec(1, 0, 252,  0,            1, 32'hDEADBEEF, 0, 0, 1, 6, "ld252");
        addVec(1, 0, 256,  0,            1, 0,            0, 0, 1, 6, "ld256");
        addVec(1, 0, 100,  0,            1, 0,            0, 0, 1, 6, "ld_mbox_run");
        addVec(1, 1, 100,  25,           1, 0,            0, 0, 1, 6, "st25_mbox");
        addVec(1, 0, 100,  0,            1, 3,            1, 1, 1, 7, "ld_mbox_pass");
        addVec(1, 1, 0,    5,            1, 11,           1, 1, 1, 7, "st5_0_pass");
        addVec(1, 0, 0,    0,            1, 11,           1, 1, 1, 7, "ld0_pass");
        addVec(0, 0, 96,   0,            1, 13,           1, 1, 1, 7, "rst_hold");
        addVec(1, 0, 96,   0,            1, 13,           0, 0, 1, 0, "ld96_after_rst");
        addVec(1, 1, 100,  24,           1, 0,            0, 0, 1, 0, "st24_mbox");
        addVec(1, 1, 0,    5,            1, 11,           1, 0, 1, 1, "st5_0_fail");
        addVec(1, 0, 0,    0,            1, 11,           1, 0, 1, 1, "ld0_fail");
        addVec(0, 1, 8,    9,            1, 32'h22,       1, 0, 1, 1, "st9_8_rst");
        addVec(1, 0, 8,    0,            1, 32'h22,       0, 0, 1, 0, "ld8_after_rst");
        addVec(1, 1, 100,  25,           1, 0,            0, 0, 1, 0, "st25_mbox2");
        addVec(1, 0, 100,  0,            1, 3,            1, 1, 1, 1, "ld_mbox_pass2");
        addVec(0, 0, 4096, 0,            1, 0,            1, 1, 1, 1, "rst_hold2");
        addVec(1, 1, 4096, 1,            1, 0,            0, 0, 1, 0, "st1_4096");
        addVec(1, 0, 0,    0,            1, 11,           1, 0, 0, 0, "ld0_after_oor");
        addVec(1, 0, 4,    0,            1, 12,           1, 0, 0, 0, "ld4_after_oor");
        addVec(1, 0, 8,    0,            1, 32'h22,       1, 0, 0, 0, "ld8_after_oor");
        addVec(1, 0, 96,   0,            1, 13,           1, 0, 0, 0, "ld96_after_oor");
        addVec(1, 0, 252,  0,            1, 32'hDEADBEEF, 1, 0, 0, 0, "ld252_after_oor");

        reset      = 1'b0;
        mem_write  = 1'b0;
        data_addr  = 32'd0;
        write_data = 32'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

        // Saturation: 65535 accepted stores reach 16'hFFFF, further ones hold it.
        reset     = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_write = 1'b1;
        data_addr = 32'd16;
        for (int i = 0; i < 65535; i++) begin
            write_data = i;
            @(posedge clk);
            #1;
        end
        vecs.delete();
        addVec(1, 1, 16,  32'hABCD, 1, 32'd65534, 0, 0, 1, 16'hFFFF, "sat_store");
        addVec(1, 0, 16,  0,        1, 32'hABCD,  0, 0, 1, 16'hFFFF, "sat_hold");
        addVec(1, 1, 100, 25,       1, 0,         0, 0, 1, 16'hFFFF, "sat_mbox");
        addVec(1, 0, 100, 0,        1, 3,         1, 1, 1, 16'hFFFF, "sat_pass");
        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

        if (exp_q.size() != 0) begin
            total_checks++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit RAM words (power of two, 4..1024).
REQ-002 Parameter MAILBOX_ADDR, default 100, byte address of the pass/fail mailbox.
REQ-003 Parameter EXPECT_DATA, default 25, store value to MAILBOX_ADDR that means pass.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 mem_write  input  1  processor store strobe for the current cycle.
REQ-007 data_addr  input  32  processor byte address.
REQ-008 write_data  input  32  processor store data.
REQ-009 read_data  output  32  load data returned to the processor.
REQ-010 done  output  1  mailbox verdict reached (sticky).
REQ-011 pass  output  1  verdict is pass; valid only when done=1.
REQ-012 store_count  output  16  number of accepted stores.

Function
REQ-013 The RAM word index SHALL be data_addr[log2(DEPTH)+1:2]; an address is in range when data_addr < 4*DEPTH.
REQ-014 read_data SHALL be combinational: mem[index] if in range; {30'b0,pass,done} if data_addr==MAILBOX_ADDR; 32'h0 otherwise.
REQ-015 The FSM SHALL have states RUN, PASS, FAIL; only RUN accepts stores.
REQ-016 In RUN, mem_write to an in-range address SHALL write write_data to mem[index] at the rising edge; a load of the same address in the next cycle returns it (write-then-read latency 1 cycle).
REQ-017 In RUN, mem_write to MAILBOX_ADDR with write_data==EXPECT_DATA SHALL move to PASS; any other value SHALL move to FAIL; the RAM is not written.
REQ-018 In RUN, mem_write to an address neither in range nor MAILBOX_ADDR SHALL move to FAIL with no RAM write.
REQ-019 If MAILBOX_ADDR falls inside the RAM range, the mailbox decode SHALL take priority.
REQ-020 PASS and FAIL SHALL be terminal until reset; stores there SHALL be ignored (no RAM write, no count).
REQ-021 done=1 in PASS or FAIL; pass=1 only in PASS; both registered outputs, asserted the cycle after the deciding store.
REQ-022 store_count SHALL increment by 1 for each store accepted in RUN (RAM or mailbox), saturating at 16'hFFFF.
REQ-023 Loads never change state; mem_write=0 cycles leave all state unchanged.

Reset
REQ-024 When reset=0 at a rising edge: state RUN, done=0, pass=0, store_count=0.
REQ-025 A store coinciding with reset=0 SHALL be ignored entirely.
REQ-026 RAM contents SHALL NOT be cleared by reset; reset mid-program preserves memory.

Configuration
REQ-027 Macro DMEM_ALIGN_CHECK_EN: when defined, a store in RUN with data_addr[1:0]!=0 SHALL move to FAIL with no RAM write, and store_count is not incremented.
REQ-028 Without DMEM_ALIGN_CHECK_EN, data_addr[1:0] SHALL be ignored for decode (word-aligned access implied).

Structure
REQ-029 The state encoding (RUN=2'd0, PASS=2'd1, FAIL=2'd2) and default MAILBOX_ADDR/EXPECT_DATA constants SHALL live in a shared package, dmem_pkg.
REQ-030 The RAM array SHALL be a sub-module dmem_ram (sync write, async read, DEPTH parameter); FSM, decode and counter stay in the top level.

Verification
REQ-031 Reset, store 7 to addr 96, load addr 96 -> read_data=7 next cycle, store_count=1, done=0.
REQ-032 Store 25 to addr 100 -> done=1, pass=1 next cycle; load addr 100 returns 32'h3.
REQ-033 Store 24 to addr 100 -> done=1, pass=0; following store 5 to addr 0 ignored, mem[0] unchanged, store_count unchanged.
REQ-034 Store 1 to addr 4096 (DEPTH=64) -> done=1, pass=0, no RAM word modified.
REQ-035 Store 9 to addr 8 with reset=0 in same cycle -> mem[2] unchanged, store_count=0; reset released, store 25 to 100 -> pass=1.
REQ-036 With DMEM_ALIGN_CHECK_EN, store to addr 98 -> done=1, pass=0; without it, same store writes mem[24] and state stays RUN.
